// File: rtl/top_control.sv
// rtl/top_control.sv - 16-bit accumulator processor top: IRAM/DRAM, PC/AR/IR/AC, ALU, FSM control.
// Optional multiply for opcode 5 when TOP_CONTROL_MUL_EN is defined; otherwise opcode 5 is a NOP.
module top_control #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              start_2,
   input  logic              start_3,
   input  logic [ADDR_W-1:0] addr_ext,
   input  logic              iram_write_ext,
   input  logic              dram_write_ext,
   input  logic [DATA_W-1:0] Data_in_ins,
   input  logic [DATA_W-1:0] Data_in_dram,
   output logic [DATA_W-1:0] iram_in,
   output logic [DATA_W-1:0] dram_in,
   output logic [DATA_W-1:0] dram_out,
   output logic [DATA_W-1:0] pc_out,
   output logic [DATA_W-1:0] ar_out,
   output logic [19:0]       control_out,
   output logic [5:0]        state,
   output logic [DATA_W-1:0] data_in_pc,
   output logic [DATA_W-1:0] alu_in_1,
   output logic [DATA_W-1:0] alu_in_2,
   output logic [DATA_W-1:0] alu_out,
   output logic              write_en,
   output logic [1:0]        read_en
);

   typedef enum logic [5:0] {
      S_IDLE    = 6'd0,
      S_FETCH   = 6'd1,
      S_FETCH_W = 6'd2,
      S_DECODE  = 6'd3,
      S_LOAD1   = 6'd4,
      S_LOAD2   = 6'd5,
      S_STORE   = 6'd6,
      S_MEM1    = 6'd7,
      S_MEM2    = 6'd8,
      S_JUMP    = 6'd9,
      S_JZ      = 6'd10,
      S_HALT    = 6'd11,
      S_INC     = 6'd12
   } state_t;

   localparam logic [3:0] OP_LD  = 4'd1;
   localparam logic [3:0] OP_ST  = 4'd2;
   localparam logic [3:0] OP_ADD = 4'd3;
   localparam logic [3:0] OP_SUB = 4'd4;
   localparam logic [3:0] OP_MUL = 4'd5;
   localparam logic [3:0] OP_JMP = 4'd6;
   localparam logic [3:0] OP_JZ  = 4'd7;
   localparam logic [3:0] OP_INC = 4'd8;
   localparam logic [3:0] OP_HLT = 4'd15;

   localparam logic [2:0] ALU_PASS = 3'd0;
   localparam logic [2:0] ALU_ADD  = 3'd1;
   localparam logic [2:0] ALU_SUB  = 3'd2;
   localparam logic [2:0] ALU_MUL  = 3'd3;
   localparam logic [2:0] ALU_INC  = 3'd4;

   state_t              cur_state, nxt_state;
   logic [DATA_W-1:0]   pc, ar, ac;
   logic [3:0]          ir_op;
   logic [ADDR_W-1:0]   ir_addr;
   logic [19:0]         ctrl;

   logic iram_rd, dram_rd, dram_wr, ir_ld, pc_inc, pc_ld, ar_ld, ac_ld, ac_src;
   logic [2:0] alu_op;

   logic [DATA_W-1:0] iram [0:(1<<ADDR_W)-1];
   logic [DATA_W-1:0] dram [0:(1<<ADDR_W)-1];
   logic              ext_mode, iram_we, dram_ext_we, dram_we;
   logic [ADDR_W-1:0] dram_addr;

   assign iram_rd = ctrl[0];
   assign dram_rd = ctrl[1];
   assign dram_wr = ctrl[2];
   assign ir_ld   = ctrl[3];
   assign pc_inc  = ctrl[4];
   assign pc_ld   = ctrl[5];
   assign ar_ld   = ctrl[6];
   assign ac_ld   = ctrl[7];
   assign alu_op  = ctrl[10:8];
   assign ac_src  = ctrl[11];

   always_ff @(posedge clock) begin
      if (reset) cur_state <= S_IDLE;
      else       cur_state <= nxt_state;
   end

   always_comb begin
      nxt_state = cur_state;
      ctrl      = '0;
      case (cur_state)
         S_IDLE: begin
            if (start && !start_2 && !start_3) nxt_state = S_FETCH;
         end
         S_FETCH: begin
            ctrl[0]   = 1'b1;
            nxt_state = S_FETCH_W;
         end
         S_FETCH_W: begin
            ctrl[3]   = 1'b1;
            ctrl[4]   = 1'b1;
            nxt_state = S_DECODE;
         end
         S_DECODE: begin
            ctrl[6] = 1'b1;
            case (ir_op)
               OP_LD:  nxt_state = S_LOAD1;
               OP_ST:  nxt_state = S_STORE;
               OP_ADD: nxt_state = S_MEM1;
               OP_SUB: nxt_state = S_MEM1;
`ifdef TOP_CONTROL_MUL_EN
               OP_MUL: nxt_state = S_MEM1;
`else
               OP_MUL: nxt_state = S_FETCH;
`endif
               OP_JMP: nxt_state = S_JUMP;
               OP_JZ:  nxt_state = S_JZ;
               OP_INC: nxt_state = S_INC;
               OP_HLT: nxt_state = S_HALT;
               default: nxt_state = S_FETCH;
            endcase
         end
         S_LOAD1: begin
            ctrl[1]   = 1'b1;
            nxt_state = S_LOAD2;
         end
         S_LOAD2: begin
            ctrl[7]    = 1'b1;
            ctrl[11]   = 1'b1;
            ctrl[10:8] = ALU_PASS;
            nxt_state  = S_FETCH;
         end
         S_STORE: begin
            ctrl[2]   = 1'b1;
            nxt_state = S_FETCH;
         end
         S_MEM1: begin
            ctrl[1]   = 1'b1;
            nxt_state = S_MEM2;
         end
         S_MEM2: begin
            ctrl[7] = 1'b1;
            case (ir_op)
               OP_ADD: ctrl[10:8] = ALU_ADD;
               OP_SUB: ctrl[10:8] = ALU_SUB;
`ifdef TOP_CONTROL_MUL_EN
               OP_MUL: ctrl[10:8] = ALU_MUL;
`endif
               default: ctrl[10:8] = ALU_PASS;
            endcase
            nxt_state = S_FETCH;
         end
         S_JUMP: begin
            ctrl[5]   = 1'b1;
            nxt_state = S_FETCH;
         end
         S_JZ: begin
            ctrl[5]   = (ac == '0);
            nxt_state = S_FETCH;
         end
         S_INC: begin
            ctrl[7]    = 1'b1;
            ctrl[10:8] = ALU_INC;
            nxt_state  = S_FETCH;
         end
         S_HALT: begin
            if (!start) nxt_state = S_IDLE;
         end
         default: nxt_state = S_IDLE;
      endcase
   end

   assign alu_in_1 = ac;
   assign alu_in_2 = dram_out;

   always_comb begin
      alu_out = alu_in_2;
      case (alu_op)
         ALU_ADD: alu_out = alu_in_1 + alu_in_2;
         ALU_SUB: alu_out = alu_in_1 - alu_in_2;
`ifdef TOP_CONTROL_MUL_EN
         ALU_MUL: alu_out = alu_in_1 * alu_in_2;
`endif
         ALU_INC: alu_out = alu_in_1 + DATA_W'(1);
         default: alu_out = alu_in_2;
      endcase
   end

   assign data_in_pc = pc_ld ? ar : pc + DATA_W'(1);

   // PC is pinned to 1 while idle and on the HALT->IDLE exit so every run restarts at address 1
   always_ff @(posedge clock) begin
      if (reset) begin
         pc      <= DATA_W'(1);
         ar      <= '0;
         ac      <= '0;
         ir_op   <= '0;
         ir_addr <= '0;
      end else begin
         if (cur_state == S_IDLE || (cur_state == S_HALT && !start))
            pc <= DATA_W'(1);
         else if (pc_inc || pc_ld)
            pc <= data_in_pc;
         if (ir_ld) begin
            ir_op   <= iram_in[15:12];
            ir_addr <= iram_in[ADDR_W-1:0];
         end
         if (ar_ld) ar <= {{(DATA_W-ADDR_W){1'b0}}, ir_addr};
         if (ac_ld) ac <= ac_src ? dram_out : alu_out;
      end
   end

   assign ext_mode    = (cur_state == S_IDLE);
   assign iram_we     = ext_mode && start_2 && iram_write_ext;
   assign dram_ext_we = ext_mode && start_3 && dram_write_ext;
   // a reset arriving in STORE must not let the write through
   assign dram_we     = dram_ext_we || (dram_wr && !reset);
   assign dram_addr   = dram_ext_we ? addr_ext : ar[ADDR_W-1:0];
   assign dram_in     = (ext_mode && start_3) ? Data_in_dram : ac;

   always_ff @(posedge clock) begin
      if (iram_we) iram[addr_ext] <= Data_in_ins;
      if (iram_rd) iram_in <= iram[pc[ADDR_W-1:0]];
   end

   always_ff @(posedge clock) begin
      if (dram_we) dram[dram_addr] <= dram_in;
      if (dram_rd) dram_out <= dram[ar[ADDR_W-1:0]];
   end

   assign pc_out      = pc;
   assign ar_out      = ar;
   assign control_out = ctrl;
   assign state       = cur_state;
   assign write_en    = dram_wr;
   assign read_en     = {iram_rd, dram_rd};

endmodule

// File: tb/tb_top_control.sv
// tb/tb_top_control.sv - directed program bench for top_control.
module tb_top_control;
   logic        clock = 1'b0;
   logic        reset, start, start_2, start_3, iram_write_ext, dram_write_ext;
   logic [8:0]  addr_ext;
   logic [15:0] Data_in_ins, Data_in_dram;
   logic [15:0] iram_in, dram_in, dram_out, pc_out, ar_out, data_in_pc;
   logic [15:0] alu_in_1, alu_in_2, alu_out;
   logic [19:0] control_out;
   logic [5:0]  state;
   logic        write_en;
   logic [1:0]  read_en;

   int vectors = 0;
   int miscompares = 0;

   top_control dut (
      .clock(clock), .reset(reset), .start(start), .start_2(start_2), .start_3(start_3),
      .addr_ext(addr_ext), .iram_write_ext(iram_write_ext), .dram_write_ext(dram_write_ext),
      .Data_in_ins(Data_in_ins), .Data_in_dram(Data_in_dram),
      .iram_in(iram_in), .dram_in(dram_in), .dram_out(dram_out), .pc_out(pc_out),
      .ar_out(ar_out), .control_out(control_out), .state(state), .data_in_pc(data_in_pc),
      .alu_in_1(alu_in_1), .alu_in_2(alu_in_2), .alu_out(alu_out),
      .write_en(write_en), .read_en(read_en)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic ld_iram(input logic [8:0] a, input logic [15:0] d);
      start_2 = 1'b1; iram_write_ext = 1'b1; addr_ext = a; Data_in_ins = d;
      tick();
      start_2 = 1'b0; iram_write_ext = 1'b0;
   endtask

   task automatic ld_dram(input logic [8:0] a, input logic [15:0] d);
      start_3 = 1'b1; dram_write_ext = 1'b1; addr_ext = a; Data_in_dram = d;
      tick();
      start_3 = 1'b0; dram_write_ext = 1'b0;
   endtask

   task automatic run_to_halt(input string tag);
      start = 1'b1;
      for (int i = 0; i < 200 && state != 6'd11; i++) tick();
      chk(tag, state, 6'd11);
   endtask

   task automatic stop();
      start = 1'b0;
      tick();
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; start_2 = 1'b0; start_3 = 1'b0;
      iram_write_ext = 1'b0; dram_write_ext = 1'b0;
      addr_ext = '0; Data_in_ins = '0; Data_in_dram = '0;
      tick(); tick();
      chk("rst_state", state, 0);
      chk("rst_pc", pc_out, 1);
      chk("rst_ar", ar_out, 0);
      chk("rst_ac", alu_in_1, 0);
      chk("rst_ctrl", control_out, 0);
      chk("rst_we", write_en, 0);
      chk("rst_re", read_en, 0);
      reset = 1'b0;

      // start ignored while a load mode is selected
      start = 1'b1; start_2 = 1'b1; tick(); tick();
      chk("idle_hold_state", state, 0);
      chk("idle_hold_pc", pc_out, 1);
      start = 1'b0; start_2 = 1'b0;

      ld_dram(9'd2, 16'h0042);
      ld_dram(9'd10, 16'd7);
      ld_dram(9'd11, 16'd5);
      ld_dram(9'd13, 16'd3);
      ld_dram(9'd14, 16'hFFFF);
      ld_dram(9'd15, 16'd300);
      ld_dram(9'd16, 16'd0);
      ld_dram(9'd17, 16'd1);

      // LD 10, ADD 11, ST 12, HLT
      ld_iram(9'd1, 16'h100A); ld_iram(9'd2, 16'h300B);
      ld_iram(9'd3, 16'h200C); ld_iram(9'd4, 16'hF000);
      run_to_halt("a_halt");
      chk("a_ac", alu_in_1, 16'd12);
      chk("a_pc", pc_out, 16'd5);
      chk("a_ar", ar_out, 16'd0);
      stop();
      chk("a_idle", state, 0);
      chk("a_idle_pc", pc_out, 1);

      // LD 12, HLT: confirms the store landed
      ld_iram(9'd1, 16'h100C); ld_iram(9'd2, 16'hF000);
      run_to_halt("b_halt");
      chk("b_dram12", alu_in_1, 16'd12);
      stop();

      // LD 13, SUB 11, HLT: 3-5 wraps
      ld_iram(9'd1, 16'h100D); ld_iram(9'd2, 16'h400B); ld_iram(9'd3, 16'hF000);
      run_to_halt("c_halt");
      chk("c_sub_wrap", alu_in_1, 16'hFFFE);
      stop();

      // LD 14, INC, HLT: FFFF+1 wraps
      ld_iram(9'd1, 16'h100E); ld_iram(9'd2, 16'h8000); ld_iram(9'd3, 16'hF000);
      run_to_halt("d_halt");
      chk("d_inc_wrap", alu_in_1, 16'h0000);
      stop();

      // LD 16 (AC=0), JZ 20 -> HLT at 20
      ld_iram(9'd1, 16'h1010); ld_iram(9'd2, 16'h7014); ld_iram(9'd3, 16'hF000);
      ld_iram(9'd20, 16'hF000);
      run_to_halt("e_halt");
      chk("e_jz_taken_pc", pc_out, 16'd21);
      chk("e_jz_ar", ar_out, 16'd0);
      stop();

      // LD 17 (AC=1), JZ 20 falls through to HLT at 3
      ld_iram(9'd1, 16'h1011);
      run_to_halt("f_halt");
      chk("f_jz_fall_pc", pc_out, 16'd4);
      chk("f_ac", alu_in_1, 16'd1);
      stop();

      // LD 15, MUL 15, HLT
      ld_iram(9'd1, 16'h100F); ld_iram(9'd2, 16'h500F); ld_iram(9'd3, 16'hF000);
      run_to_halt("g_halt");
`ifdef TOP_CONTROL_MUL_EN
      chk("g_mul", alu_in_1, 16'h5F90);
`else
      chk("g_mul_nop", alu_in_1, 16'h012C);
`endif
      stop();

      // LD 10, ST 16, HLT with reset asserted in STORE
      ld_iram(9'd1, 16'h100A); ld_iram(9'd2, 16'h2010); ld_iram(9'd3, 16'hF000);
      start = 1'b1;
      for (int i = 0; i < 50 && state != 6'd6; i++) tick();
      chk("h_store_reached", state, 6'd6);
      chk("h_store_ctrl", control_out, 20'h00004);
      chk("h_store_we", write_en, 1);
      chk("h_store_data", dram_in, 16'd7);
      reset = 1'b1; start = 1'b0;
      tick();
      chk("h_rst_state", state, 0);
      chk("h_rst_pc", pc_out, 1);
      chk("h_rst_ac", alu_in_1, 0);
      reset = 1'b0;

      // LD 16, INC, HLT: DRAM[16] must still be 0
      ld_iram(9'd1, 16'h1010); ld_iram(9'd2, 16'h8000); ld_iram(9'd3, 16'hF000);
      run_to_halt("h2_halt");
      chk("h2_no_write", alu_in_1, 16'd1);
      stop();

      // LD 2, HLT with external writes attempted during the run
      ld_iram(9'd1, 16'h1002); ld_iram(9'd2, 16'hF000);
      start = 1'b1;
      tick();
      chk("i_fetch_state", state, 6'd1);
      chk("i_fetch_ctrl", control_out, 20'h00001);
      chk("i_fetch_re", read_en, 2'b10);
      start_2 = 1'b1; iram_write_ext = 1'b1; start_3 = 1'b1; dram_write_ext = 1'b1;
      addr_ext = 9'd2; Data_in_ins = 16'h8000; Data_in_dram = 16'h0055;
      run_to_halt("i_halt");
      chk("i_dram_kept", alu_in_1, 16'h0042);
      chk("i_iram_kept_pc", pc_out, 16'd3);
      start_2 = 1'b0; iram_write_ext = 1'b0; start_3 = 1'b0; dram_write_ext = 1'b0;
      stop();
      chk("i_idle", state, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
